// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-to-UART transmitter.
//   state_t : transmitter FSM state encoding (3-bit)
//   TX_IDLE : serial line level when no frame is being sent
package fifo_uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      POP    = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      PARITY = 3'd5,
      STOP   = 3'd6
   } state_t;

   localparam logic TX_IDLE = 1'b1;

endpackage

// File: rtl/fifo_uart_bit_timer.sv
// Bit-period timer for the UART transmitter.
//   rd_clk   : clock (rising edge)
//   rst_n    : synchronous active-low reset
//   enable   : count while high; held at zero while low
//   bit_tick : high on the last cycle of each CLKS_PER_BIT-cycle bit period
module fifo_uart_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic rd_clk,
   input  logic rst_n,
   input  logic enable,
   output logic bit_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] tick_cnt;

   always_ff @(posedge rd_clk) begin
      if (!rst_n || !enable) begin
         tick_cnt <= '0;
      end else if (tick_cnt == TERMINAL) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   assign bit_tick = enable && (tick_cnt == TERMINAL);

endmodule

// File: rtl/fifo_uart_tx.sv
// Read-side FIFO consumer that serialises each popped byte as a UART frame.
//   rd_clk     : FIFO read clock, all logic on its rising edge
//   rst_n      : synchronous active-low reset
//   fifo_empty : FIFO empty flag
//   fifo_dout  : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en : single-cycle pop strobe (registered)
//   tx         : serial line, idle high (registered)
//   busy       : high whenever the FSM is not in IDLE (registered)
//   byte_cnt   : frames fully transmitted since reset, wraps (registered)
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              rd_clk,
   input  logic              rst_n,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_rd_en,
   output logic              tx,
   output logic              busy,
   output logic [15:0]       byte_cnt
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
   localparam logic LAST_STOP = 1'(STOP_BITS - 1);

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic              parity_bit;
   logic [IDX_W-1:0]  bit_idx;
   logic              stop_idx;
   logic              timer_en;
   logic              bit_tick;

   // The timer runs only while a frame is on the line, so every frame starts
   // with a fresh, full-length start bit.
   always_comb begin
      timer_en = 1'b0;
      if (state inside {START, DATA, PARITY, STOP}) timer_en = 1'b1;
   end

   fifo_uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .rd_clk   (rd_clk),
      .rst_n    (rst_n),
      .enable   (timer_en),
      .bit_tick (bit_tick)
   );

   // Outputs are updated together with the state they belong to, so tx and
   // busy always reflect the state that is current in the same cycle.
   always_ff @(posedge rd_clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         tx         <= TX_IDLE;
         fifo_rd_en <= 1'b0;
         busy       <= 1'b0;
         byte_cnt   <= '0;
         shreg      <= '0;
         parity_bit <= 1'b0;
         bit_idx    <= '0;
         stop_idx   <= 1'b0;
      end else begin
         fifo_rd_en <= 1'b0;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  state      <= POP;
                  fifo_rd_en <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            POP: begin
               state <= LOAD;
            end
            LOAD: begin
               shreg      <= fifo_dout;
               parity_bit <= ^fifo_dout;
               state      <= START;
               tx         <= 1'b0;
            end
            START: begin
               if (bit_tick) begin
                  state   <= DATA;
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_idx <= '0;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  if (bit_idx == LAST_IDX) begin
                     if (PARITY_EN != 0) begin
                        state <= PARITY;
                        tx    <= parity_bit;
                     end else begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        stop_idx <= 1'b0;
                     end
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end
            end
            PARITY: begin
               if (bit_tick) begin
                  state    <= STOP;
                  tx       <= 1'b1;
                  stop_idx <= 1'b0;
               end
            end
            STOP: begin
               if (bit_tick) begin
                  if (stop_idx == LAST_STOP) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     byte_cnt <= byte_cnt + 16'd1;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               tx    <= TX_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: three instances (plain 8N1, even parity,
// two stop bits), each fed by a small non-FWFT FIFO model.
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   logic rd_clk = 1'b0;
   logic rst_n;
   always #5 rd_clk = ~rd_clk;

   // FIFO models: registered read data one cycle after rd_en
   logic [7:0] mem0 [0:31];
   logic [7:0] mem1 [0:31];
   logic [7:0] mem2 [0:31];
   int wp0 = 0, wp1 = 0, wp2 = 0;
   int rp0 = 0, rp1 = 0, rp2 = 0;
   logic [7:0] dout0, dout1, dout2;
   logic empty0, empty1, empty2;
   assign empty0 = (wp0 == rp0);
   assign empty1 = (wp1 == rp1);
   assign empty2 = (wp2 == rp2);

   logic rd0, rd1, rd2;
   logic tx0, tx1, tx2;
   logic busy0, busy1, busy2;
   logic [15:0] cnt0, cnt1, cnt2;

   int rd_pulses0 = 0;

   always @(posedge rd_clk) begin
      if (rd0) begin
         dout0 <= mem0[rp0[4:0]];
         rp0   <= rp0 + 1;
         rd_pulses0 <= rd_pulses0 + 1;
      end
      if (rd1) begin
         dout1 <= mem1[rp1[4:0]];
         rp1   <= rp1 + 1;
      end
      if (rd2) begin
         dout2 <= mem2[rp2[4:0]];
         rp2   <= rp2 + 1;
      end
   end

   fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u_dut (
      .rd_clk(rd_clk), .rst_n(rst_n), .fifo_empty(empty0), .fifo_dout(dout0),
      .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .byte_cnt(cnt0));

   fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) u_par (
      .rd_clk(rd_clk), .rst_n(rst_n), .fifo_empty(empty1), .fifo_dout(dout1),
      .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .byte_cnt(cnt1));

   fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) u_stop2 (
      .rd_clk(rd_clk), .rst_n(rst_n), .fifo_empty(empty2), .fifo_dout(dout2),
      .fifo_rd_en(rd2), .tx(tx2), .busy(busy2), .byte_cnt(cnt2));

   // Observation mux over the instance under test
   int sel = 0;
   logic rd_s, tx_s, busy_s;
   logic [15:0] cnt_s;
   always_comb begin
      rd_s = rd0; tx_s = tx0; busy_s = busy0; cnt_s = cnt0;
      case (sel)
         1: begin rd_s = rd1; tx_s = tx1; busy_s = busy1; cnt_s = cnt1; end
         2: begin rd_s = rd2; tx_s = tx2; busy_s = busy2; cnt_s = cnt2; end
         default: ;
      endcase
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic push(input int which, input logic [7:0] d);
      case (which)
         0: begin mem0[wp0[4:0]] = d; wp0 = wp0 + 1; end
         1: begin mem1[wp1[4:0]] = d; wp1 = wp1 + 1; end
         default: begin mem2[wp2[4:0]] = d; wp2 = wp2 + 1; end
      endcase
   endtask

   // Advance until fifo_rd_en is seen; n = cycles waited (bounded).
   task automatic wait_rd(input string tag, output int n);
      n = 0;
      while (rd_s !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk({tag, " rd_en seen"}, 32'(rd_s), 32'd1);
   endtask

   // Entered at the sample where fifo_rd_en is high. bits[i] is the line
   // level of bit period i (start first). Leaves at the first IDLE cycle.
   task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits);
      tick();
      chk({tag, " rd_en one cycle"}, 32'(rd_s), 32'd0);
      chk({tag, " tx high in LOAD"}, 32'(tx_s), 32'd1);
      tick();
      chk({tag, " start fall"}, 32'(tx_s), 32'd0);
      tick();
      tick();
      for (int i = 0; i < nbits; i++) begin
         chk($sformatf("%s bit%0d", tag, i), 32'(tx_s), 32'(bits[i]));
         if (i != nbits - 1) repeat (CPB) tick();
      end
      tick();
      chk({tag, " last cycle busy"}, 32'(busy_s), 32'd1);
      chk({tag, " last cycle tx"}, 32'(tx_s), 32'd1);
      tick();
      chk({tag, " idle busy"}, 32'(busy_s), 32'd0);
      chk({tag, " idle tx"}, 32'(tx_s), 32'd1);
   endtask

   initial begin
      int n;
      int p0;
      bit seen;
      logic [7:0] b;

      // Reset held 3 cycles with data queued
      sel   = 0;
      rst_n = 1'b0;
      push(0, 8'hA5);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset tx", 32'(tx0), 32'd1);
         chk("reset rd_en", 32'(rd0), 32'd0);
         chk("reset busy", 32'(busy0), 32'd0);
         chk("reset byte_cnt", 32'(cnt0), 32'd0);
      end

      // Single byte 0xA5: levels 0,1,0,1,0,0,1,0,1,1 (start..stop)
      rst_n = 1'b1;
      wait_rd("a5", n);
      chk("a5 pop latency", 32'(n), 32'd1);
      chk("a5 byte_cnt before", 32'(cnt0), 32'd0);
      check_frame("a5", 16'h034A, 10);
      chk("a5 byte_cnt", 32'(cnt0), 32'd1);

      // Burst 00..05 after a fresh reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      p0 = rd_pulses0;
      for (int i = 0; i < 6; i++) push(0, 8'(i));
      wait_rd("burst0", n);
      chk("burst first latency", 32'(n), 32'd1);
      for (int i = 0; i < 6; i++) begin
         b = 8'(i);
         if (i != 0) begin
            wait_rd($sformatf("burst%0d", i), n);
            chk($sformatf("burst%0d gap", i), 32'(n), 32'd1);
         end
         check_frame($sformatf("burst%0d", i), {7'd0, 1'b1, b, 1'b0}, 10);
      end
      repeat (10) tick();
      chk("burst busy low", 32'(busy0), 32'd0);
      chk("burst rd_en pulses", 32'(rd_pulses0 - p0), 32'd6);
      chk("burst byte_cnt", 32'(cnt0), 32'd6);

      // Mid-frame reset during data bit 3 of 0xFF
      push(0, 8'hFF);
      wait_rd("midrst", n);
      tick();
      tick();
      repeat (17) tick();
      chk("midrst busy before", 32'(busy0), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst tx", 32'(tx0), 32'd1);
      chk("midrst busy", 32'(busy0), 32'd0);
      chk("midrst byte_cnt", 32'(cnt0), 32'd0);
      seen = 1'b0;
      repeat (20) begin
         tick();
         if (rd0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) seen = 1'b1;
      end
      chk("midrst stays idle", 32'(seen), 32'd0);
      push(0, 8'h5A);
      wait_rd("post_rst", n);
      check_frame("post_rst", {7'd0, 1'b1, 8'h5A, 1'b0}, 10);
      chk("post_rst byte_cnt", 32'(cnt0), 32'd1);

      // Even parity: 0x07 -> 1, 0x0F -> 0, 44-cycle frames
      sel = 1;
      push(1, 8'h07);
      push(1, 8'h0F);
      wait_rd("par07", n);
      check_frame("par07", {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
      wait_rd("par0f", n);
      chk("par0f gap", 32'(n), 32'd1);
      check_frame("par0f", {5'd0, 1'b1, 1'b0, 8'h0F, 1'b0}, 11);
      chk("par byte_cnt", 32'(cnt1), 32'd2);

      // Two stop bits, byte 0x3C, 44-cycle frame
      sel = 2;
      push(2, 8'h3C);
      wait_rd("stop2", n);
      check_frame("stop2", {5'd0, 2'b11, 8'h3C, 1'b0}, 11);
      chk("stop2 byte_cnt", 32'(cnt2), 32'd1);
      chk("stop2 other inst idle", 32'(cnt0), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog timeout");
   end

endmodule
